// File: rtl/sub_bundle_fifo.sv
// sub_bundle_fifo
//   First-word-fall-through FIFO that carries a bundle of four payload
//   shapes (scalar, vector, packed 2D array, unpacked 2D array) from a
//   producer to a consumer. Both sides use valid/ready handshakes. It also
//   reports occupancy, supports a synchronous flush, and keeps a sticky flag
//   that records upstream protocol violations.
//
// Ports
//   i_clk, i_rst_n         rising-edge clock, async active-low reset
//   i_flush                sync flush: empties the FIFO and clears o_proto_err
//   i_valid / o_ready      upstream handshake (o_ready = !o_full)
//   i_sig_a..i_sig_d       upstream payload: scalar, vector, packed, unpacked
//   o_valid / i_ready      downstream handshake (o_valid = !o_empty)
//   o_sig_e..o_sig_h       head payload, forced to zero while o_valid = 0
//   o_count                entries held, 0..DEPTH
//   o_full, o_empty        occupancy flags
//   o_proto_err            sticky: upstream dropped or changed a stalled payload
module sub_bundle_fifo #(
  parameter int VEC_W    = 2,
  parameter int ELEM_W   = 8,
  parameter int NUM_ELEM = 3,
  parameter int DEPTH    = 4
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_flush,
  input  logic                                i_valid,
  output logic                                o_ready,
  input  logic                                i_sig_a,
  input  logic [VEC_W-1:0]                    i_sig_b,
  input  logic [0:NUM_ELEM-1][ELEM_W-1:0]     i_sig_c,
  input  logic [ELEM_W-1:0]                   i_sig_d [0:NUM_ELEM-1],
  output logic                                o_valid,
  input  logic                                i_ready,
  output logic                                o_sig_e,
  output logic [VEC_W-1:0]                    o_sig_f,
  output logic [0:NUM_ELEM-1][ELEM_W-1:0]     o_sig_g,
  output logic [ELEM_W-1:0]                   o_sig_h [0:NUM_ELEM-1],
  output logic [$clog2(DEPTH+1)-1:0]          o_count,
  output logic                                o_full,
  output logic                                o_empty,
  output logic                                o_proto_err
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic                            mem_a [0:DEPTH-1];
  logic [VEC_W-1:0]                mem_b [0:DEPTH-1];
  logic [0:NUM_ELEM-1][ELEM_W-1:0] mem_c [0:DEPTH-1];
  logic [ELEM_W-1:0]               mem_d [0:DEPTH-1][0:NUM_ELEM-1];

  logic                            stall_q;
  logic                            stall_a;
  logic [VEC_W-1:0]                stall_b;
  logic [0:NUM_ELEM-1][ELEM_W-1:0] stall_c;
  logic [ELEM_W-1:0]               stall_d [0:NUM_ELEM-1];
  logic                            payload_diff;
  logic                            proto_err;

  logic push;
  logic pop;

  // All handshake flags come from the count register alone, so neither
  // i_valid nor i_ready can reach o_valid or o_ready through logic.
  assign o_full      = (count == CNT_W'(DEPTH));
  assign o_empty     = (count == '0);
  assign o_ready     = !o_full;
  assign o_valid     = !o_empty;
  assign o_count     = count;
  assign o_proto_err = proto_err;

  assign push = i_valid && o_ready;
  assign pop  = o_valid && i_ready;

  // Pointer and occupancy bookkeeping. Flush takes priority over push and pop.
  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage. No reset is needed here, because unread contents never
  // reach the outputs: the output gating hides anything beyond the count.
  always_ff @(posedge i_clk) begin
    if (push && !i_flush) begin
      mem_a[wr_ptr] <= i_sig_a;
      mem_b[wr_ptr] <= i_sig_b;
      mem_c[wr_ptr] <= i_sig_c;
      for (int k = 0; k < NUM_ELEM; k++) mem_d[wr_ptr][k] <= i_sig_d[k];
    end
  end

  // Head presentation. The outputs are zeroed whenever the FIFO is empty,
  // so they match the reset values even while stale entries remain in memory.
  always_comb begin
    o_sig_e = 1'b0;
    o_sig_f = '0;
    o_sig_g = '0;
    for (int k = 0; k < NUM_ELEM; k++) o_sig_h[k] = '0;
    if (o_valid) begin
      o_sig_e = mem_a[rd_ptr];
      o_sig_f = mem_b[rd_ptr];
      o_sig_g = mem_c[rd_ptr];
      for (int k = 0; k < NUM_ELEM; k++) o_sig_h[k] = mem_d[rd_ptr][k];
    end
  end

  // Compare the current payload against the one captured in the previous cycle.
  always_comb begin
    payload_diff = (i_sig_a != stall_a) || (i_sig_b != stall_b) || (i_sig_c != stall_c);
    for (int k = 0; k < NUM_ELEM; k++) begin
      if (i_sig_d[k] != stall_d[k]) payload_diff = 1'b1;
    end
  end

  // Protocol watchdog. When upstream was stalled last cycle, it must keep
  // i_valid high and the payload unchanged. Flush clears both the sticky
  // flag and any pending stall, so a flush cycle can never raise an error.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_q   <= 1'b0;
      proto_err <= 1'b0;
      stall_a   <= 1'b0;
      stall_b   <= '0;
      stall_c   <= '0;
      for (int k = 0; k < NUM_ELEM; k++) stall_d[k] <= '0;
    end else begin
      stall_a <= i_sig_a;
      stall_b <= i_sig_b;
      stall_c <= i_sig_c;
      for (int k = 0; k < NUM_ELEM; k++) stall_d[k] <= i_sig_d[k];
      if (i_flush) begin
        stall_q   <= 1'b0;
        proto_err <= 1'b0;
      end else begin
        stall_q <= i_valid && !o_ready;
        if (stall_q && (!i_valid || payload_diff)) proto_err <= 1'b1;
      end
    end
  end

endmodule
